demux_1xn_stripe: RTL and testbench

- Parametrised single-clock successor to the 1x2 byte demux in the PHY receive path.
- Stripes a serial stream of DATA_W-bit words round-robin across LANES output lanes and presents each completed group on all lanes in the same cycle.
- The active lane count is selectable at run time.
- Partial groups are flushed on an idle timeout or on an explicit flush request.

---
 rtl/demux_1xn_stripe.sv | 147 ++++++++++++++
 tb/tb_demux_1xn_stripe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1xn_stripe.sv
//==============================================================================
// Module      : demux_1xn_stripe
// Description : Stripes a serial stream of DATA_W-bit words round-robin across
//               up to LANES output lanes. Each completed group appears on all
//               lanes in the same cycle. The active lane count is taken from
//               lane_cfg at each group start. A partial group is emitted on
//               an idle timeout or on an explicit flush.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module demux_1xn_stripe #(
    parameter int DATA_W       = 8,
    parameter int LANES        = 4,
    parameter int IDLE_TIMEOUT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [1:0]                lane_cfg,
    input  logic                      flush,
    output logic [LANES-1:0]          out_valid,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic                      out_partial,
    output logic [7:0]                grp_cnt
);

    localparam int PTR_W = $clog2(LANES);
    localparam int IDL_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [3:0]       C_LANES     = 4'(LANES);
    localparam logic [IDL_W-1:0] C_IDLE_LAST = IDL_W'(IDLE_TIMEOUT - 1);

    // Group assembly state
    logic [PTR_W-1:0]                ptr_q, ptr_d;
    logic [3:0]                      act_q, act_d;
    logic [LANES-1:0][DATA_W-1:0]    stage_q, stage_d;
    logic [LANES-1:0]                stv_q, stv_d;
    logic [IDL_W-1:0]                idle_q, idle_d;

    // Output registers
    logic [LANES-1:0]                out_valid_q, out_valid_d;
    logic [LANES*DATA_W-1:0]         out_data_q, out_data_d;
    logic                            out_partial_q, out_partial_d;
    logic [7:0]                      grp_q, grp_d;

    // Decoded and clamped lane request, plus emit qualifiers
    logic [3:0]                      cfg_cnt;
    logic [3:0]                      cfg_clamp;
    logic                            full_grp;
    logic                            timeout;
    logic                            partial;
    logic                            emit;

    // Translate the 2-bit lane code into a lane count no larger than LANES
    always_comb begin
        cfg_cnt   = 4'd1 << lane_cfg;
        cfg_clamp = (cfg_cnt > C_LANES) ? C_LANES : cfg_cnt;
    end

    // Next-state logic: accept the incoming word, then decide whether to emit
    always_comb begin
        act_d         = act_q;
        ptr_d         = ptr_q;
        stage_d       = stage_q;
        stv_d         = stv_q;
        out_valid_d   = '0;
        out_partial_d = 1'b0;
        out_data_d    = out_data_q;
        grp_d         = grp_q;

        // The lane count is sampled only at the first word of a group
        if ((ptr_q == '0) && in_valid) begin
            act_d = cfg_clamp;
        end

        // Full when this word lands in the last active lane of the group
        full_grp = in_valid && (4'(ptr_q) == (act_d - 4'd1));

        // Timeout fires on the idle edge that completes IDLE_TIMEOUT idle cycles
        timeout  = !in_valid && (ptr_q != '0) && (idle_q == C_IDLE_LAST);

        if (in_valid) begin
            stage_d[ptr_q] = in_data;
            stv_d[ptr_q]   = 1'b1;
            ptr_d          = ptr_q + PTR_W'(1);
        end

        // A flush or timeout only counts as partial if the group is not already full
        partial = !full_grp && (timeout || (flush && (|stv_d)));
        emit    = full_grp || partial;

        if (emit) begin
            out_valid_d   = stv_d;
            out_partial_d = partial;
            grp_d         = grp_q + 8'd1;
            for (int i = 0; i < LANES; i++) begin
                if (stv_d[i]) begin
                    out_data_d[i*DATA_W +: DATA_W] = stage_d[i];
                end
            end
            ptr_d = '0;
            stv_d = '0;
        end

        // Idle counting runs only while a partial group is pending
        if ((ptr_d == '0) || in_valid) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + IDL_W'(1);
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q         <= '0;
            act_q         <= 4'd1;
            stage_q       <= '0;
            stv_q         <= '0;
            idle_q        <= '0;
            out_valid_q   <= '0;
            out_data_q    <= '0;
            out_partial_q <= 1'b0;
            grp_q         <= '0;
        end else begin
            ptr_q         <= ptr_d;
            act_q         <= act_d;
            stage_q       <= stage_d;
            stv_q         <= stv_d;
            idle_q        <= idle_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_partial_q <= out_partial_d;
            grp_q         <= grp_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_partial = out_partial_q;
    assign grp_cnt     = grp_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_1xn_stripe.sv
//==============================================================================
// Module      : tb_demux_1xn_stripe
// Description : Directed self-checking bench for demux_1xn_stripe with an
//               expected-emit scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_demux_1xn_stripe;

    localparam int DW = 8;
    localparam int LN = 4;
    localparam int IT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic [1:0]        lane_cfg;
    logic              flush;
    logic [LN-1:0]     out_valid;
    logic [LN*DW-1:0]  out_data;
    logic              out_partial;
    logic [7:0]        grp_cnt;

    demux_1xn_stripe #(
        .DATA_W       (DW),
        .LANES        (LN),
        .IDLE_TIMEOUT (IT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .lane_cfg    (lane_cfg),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_partial (out_partial),
        .grp_cnt     (grp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LN-1:0]    v;
        logic [LN*DW-1:0] d;
        logic             p;
        logic [7:0]       g;
    } exp_t;

    exp_t             sb[$];
    int               errors = 0;
    int               checks = 0;
    logic [LN*DW-1:0] shadow;
    logic [7:0]       gexp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record an expected emit; lanes not flagged keep their previous contents
    task automatic expect_emit(input logic [LN-1:0] v, input logic [DW-1:0] w0,
                               input logic [DW-1:0] w1, input logic [DW-1:0] w2,
                               input logic [DW-1:0] w3, input logic p);
        exp_t          e;
        logic [DW-1:0] w [LN];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < LN; i++) begin
            if (v[i]) shadow[i*DW +: DW] = w[i];
        end
        gexp = gexp + 8'd1;
        e.v = v; e.d = shadow; e.p = p; e.g = gexp;
        sb.push_back(e);
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic [1:0] cfg, input logic fl);
        in_valid = v; in_data = d; lane_cfg = cfg; flush = fl;
        @(posedge clk);
        #1;
    endtask

    // Every emit seen on the outputs must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && out_valid !== '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_emit", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_valid",   64'(out_valid),   64'(e.v));
                chk("sb_data",    64'(out_data),    64'(e.d));
                chk("sb_partial", 64'(out_partial), 64'(e.p));
                chk("sb_grp",     64'(grp_cnt),     64'(e.g));
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; lane_cfg = 2'd2; flush = 1'b0;
        shadow = '0; gexp = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   64'(out_valid),   64'd0);
        chk("rst_data",    64'(out_data),    64'd0);
        chk("rst_partial", 64'(out_partial), 64'd0);
        chk("rst_grp",     64'(grp_cnt),     64'd0);
        reset = 1'b0;
        step(0, 8'h00, 2'd2, 0);

        // Full 4-lane group with one-cycle latency and pulse output
        step(1, 8'h11, 2'd2, 0);
        step(1, 8'h22, 2'd2, 0);
        step(1, 8'h33, 2'd2, 0);
        expect_emit(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 0);
        step(1, 8'h44, 2'd2, 0);
        chk("t1_valid", 64'(out_valid), 64'hF);
        chk("t1_data",  64'(out_data),  64'h44332211);
        chk("t1_grp",   64'(grp_cnt),   64'd1);
        step(0, 8'h00, 2'd2, 0);
        chk("t1_pulse", 64'(out_valid), 64'd0);
        chk("t1_hold",  64'(out_data),  64'h44332211);

        // Two-lane groups; upper lanes keep old data
        step(1, 8'hA0, 2'd1, 0);
        expect_emit(4'b0011, 8'hA0, 8'hA1, 8'h00, 8'h00, 0);
        step(1, 8'hA1, 2'd1, 0);
        step(1, 8'hA2, 2'd1, 0);
        expect_emit(4'b0011, 8'hA2, 8'hA3, 8'h00, 8'h00, 0);
        step(1, 8'hA3, 2'd1, 0);
        chk("t2_grp",  64'(grp_cnt),  64'(gexp));
        chk("t2_data", 64'(out_data), 64'h4433A3A2);
        step(0, 8'h00, 2'd2, 0);

        // Idle timeout emits a partial group on the 4th idle edge
        step(1, 8'h55, 2'd2, 0);
        step(1, 8'h66, 2'd2, 0);
        step(0, 8'h00, 2'd2, 0);
        step(0, 8'h00, 2'd2, 0);
        step(0, 8'h00, 2'd2, 0);
        chk("t3_no_early", 64'(out_valid), 64'd0);
        expect_emit(4'b0011, 8'h55, 8'h66, 8'h00, 8'h00, 1);
        step(0, 8'h00, 2'd2, 0);
        chk("t3_partial", 64'(out_partial), 64'd1);
        chk("t3_valid",   64'(out_valid),   64'h3);

        // A word on the 4th idle edge cancels the timeout and lands in lane 2
        step(1, 8'h77, 2'd2, 0);
        step(1, 8'h88, 2'd2, 0);
        step(0, 8'h00, 2'd2, 0);
        step(0, 8'h00, 2'd2, 0);
        step(0, 8'h00, 2'd2, 0);
        step(1, 8'h99, 2'd2, 0);
        chk("t3_cancel", 64'(out_valid), 64'd0);
        expect_emit(4'b1111, 8'h77, 8'h88, 8'h99, 8'hAA, 0);
        step(1, 8'hAA, 2'd2, 0);
        chk("t3_full_after", 64'(out_data), 64'hAA998877);

        // Flush with a same-edge word; then flush with nothing pending
        step(1, 8'h01, 2'd2, 0);
        expect_emit(4'b0011, 8'h01, 8'h02, 8'h00, 8'h00, 1);
        step(1, 8'h02, 2'd2, 1);
        chk("t4_partial", 64'(out_partial), 64'd1);
        chk("t4_data",    64'(out_data),    64'hAA990201);
        step(0, 8'h00, 2'd2, 1);
        chk("t4_noop_valid", 64'(out_valid), 64'd0);
        chk("t4_noop_grp",   64'(grp_cnt),   64'(gexp));

        // Flush together with the last word of a full group is a normal emit
        step(1, 8'h03, 2'd2, 0);
        step(1, 8'h04, 2'd2, 0);
        step(1, 8'h05, 2'd2, 0);
        expect_emit(4'b1111, 8'h03, 8'h04, 8'h05, 8'h06, 0);
        step(1, 8'h06, 2'd2, 1);
        chk("t4_full_flush_partial", 64'(out_partial), 64'd0);

        // lane_cfg change mid-group takes effect at the next group
        step(1, 8'hB0, 2'd2, 0);
        step(1, 8'hB1, 2'd0, 0);
        step(1, 8'hB2, 2'd0, 0);
        expect_emit(4'b1111, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 0);
        step(1, 8'hB3, 2'd0, 0);
        expect_emit(4'b0001, 8'hC0, 8'h00, 8'h00, 8'h00, 0);
        step(1, 8'hC0, 2'd0, 0);
        chk("t5_one_lane", 64'(out_valid), 64'h1);
        expect_emit(4'b0001, 8'hC1, 8'h00, 8'h00, 8'h00, 0);
        step(1, 8'hC1, 2'd0, 0);
        chk("t5_grp", 64'(grp_cnt), 64'(gexp));

        // Asynchronous reset mid-group clears everything without an emit
        step(1, 8'hD0, 2'd2, 0);
        step(1, 8'hD1, 2'd2, 0);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        chk("t6_async_data",  64'(out_data),  64'd0);
        chk("t6_async_grp",   64'(grp_cnt),   64'd0);
        shadow = '0; gexp = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1, 8'hE0, 2'd2, 0);
        step(1, 8'hE1, 2'd2, 0);
        step(1, 8'hE2, 2'd2, 0);
        expect_emit(4'b1111, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 0);
        step(1, 8'hE3, 2'd2, 0);
        chk("t6_grp",  64'(grp_cnt),  64'd1);
        chk("t6_data", 64'(out_data), 64'hE3E2E1E0);
        step(0, 8'h00, 2'd2, 0);
        step(0, 8'h00, 2'd2, 0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
